// File: rtl/pc_ctrl.sv
// Next-PC selection for the fetch stage: boot vector, sequential fetch,
// prioritised trap/jump/branch redirects, memory back-pressure and halt.
module pc_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic        imem_ready_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        trap_i,
    input  logic        halt_i,
    output logic [31:0] pc_next_o,
    output logic        pc_write_en_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic [1:0]  state_o,
    output logic [31:0] trap_epc_o,
    output logic [1:0]  trap_cause_o,
    output logic [15:0] redirect_cnt_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_TRAP     = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

    state_t      state_q, state_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] epc_q;
    logic [1:0]  cause_q;
    logic [15:0] cnt_q;

    logic        redir_req;
    logic        misaligned;
    logic [31:0] raw_target;
    logic [31:0] redir_target;
    logic [1:0]  redir_cause;
    logic        accept;
    logic        take_trap;
    logic [1:0]  take_cause;
    logic        flush;

    // Trap outranks jump, jump outranks branch; a misaligned jump/branch target
    // is itself turned into a trap.
    always_comb begin : redirect_decode
        redir_req    = trap_i | jump_i | branch_taken_i;
        raw_target   = jump_i ? jump_target_i : branch_target_i;
        misaligned   = !trap_i && (jump_i || branch_taken_i) && (raw_target[1:0] != 2'b00);
        redir_target = (trap_i || misaligned) ? TRAP_VECTOR : raw_target;
        redir_cause  = trap_i ? CAUSE_TRAP : CAUSE_MISALIGN;
    end

    always_comb begin : fsm_comb
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        pend_d        = pend_q;
        pc_next_o     = pc_i + 32'd4;
        pc_write_en_o = 1'b0;
        flush         = 1'b0;
        accept        = 1'b0;
        take_trap     = 1'b0;
        take_cause    = redir_cause;
        case (state_q)
            ST_BOOT: begin
                pc_next_o     = RESET_VECTOR;
                pc_write_en_o = 1'b1;
                state_d       = ST_RUN;
            end
            ST_RUN: begin
                if (redir_req) begin
                    accept    = 1'b1;
                    flush     = 1'b1;
                    take_trap = trap_i | misaligned;
                    pc_next_o = redir_target;
                    if (imem_ready_i) begin
                        pc_write_en_o = 1'b1;
                    end else begin
                        pend_d  = redir_target;
                        state_d = ST_WAIT;
                    end
                end else if (halt_i) begin
                    state_d = ST_HALT;
                end else begin
                    pc_write_en_o = imem_ready_i & ~stall_i;
                end
            end
            ST_WAIT: begin
                // Only a trap may disturb a parked redirect; it replaces the target.
                pc_write_en_o = imem_ready_i;
                pc_next_o     = pend_q;
                if (trap_i) begin
                    accept     = 1'b1;
                    flush      = 1'b1;
                    take_trap  = 1'b1;
                    take_cause = CAUSE_TRAP;
                    pc_next_o  = TRAP_VECTOR;
                    pend_d     = TRAP_VECTOR;
                end
                if (imem_ready_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                pc_next_o = pc_i;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= ST_BOOT;
            pend_q  <= '0;
            epc_q   <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (take_trap) begin
                epc_q   <= pc_i;
                cause_q <= take_cause;
            end
            if (accept && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign flush_if_id_o  = flush;
    assign flush_id_ex_o  = flush;
    assign state_o        = state_q;
    assign trap_epc_o     = epc_q;
    assign trap_cause_o   = cause_q;
    assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_pc_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_WAIT = 2;
    localparam int M_HALT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_i = '0;
    logic        imem_ready_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_target_i = '0;
    logic        trap_i = 1'b0;
    logic        halt_i = 1'b0;
    logic [31:0] pc_next_o;
    logic        pc_write_en_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic [1:0]  state_o;
    logic [31:0] trap_epc_o;
    logic [1:0]  trap_cause_o;
    logic [15:0] redirect_cnt_o;

    always #5 clk = ~clk;

    pc_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_i            (pc_i),
        .imem_ready_i    (imem_ready_i),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .trap_i          (trap_i),
        .halt_i          (halt_i),
        .pc_next_o       (pc_next_o),
        .pc_write_en_o   (pc_write_en_o),
        .flush_if_id_o   (flush_if_id_o),
        .flush_id_ex_o   (flush_id_ex_o),
        .state_o         (state_o),
        .trap_epc_o      (trap_epc_o),
        .trap_cause_o    (trap_cause_o),
        .redirect_cnt_o  (redirect_cnt_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode, parked target, last trap record, redirect tally.
    int          m_mode = M_BOOT;
    logic [31:0] m_pend = '0;
    logic [31:0] m_epc = '0;
    logic [1:0]  m_cause = '0;
    int          m_cnt = 0;

    always @(negedge clk) begin : compare
        bit          redir, e_we, e_fl;
        logic [31:0] tgt, e_next;
        logic [1:0]  tcause;
        int          nxt;
        if (!rst_n) begin
            m_mode = M_BOOT; m_pend = '0; m_epc = '0; m_cause = '0; m_cnt = 0;
            check("rst_state", state_o, 0);
            check("rst_epc", trap_epc_o, 0);
            check("rst_cause", trap_cause_o, 0);
            check("rst_cnt", redirect_cnt_o, 0);
        end else begin
            redir = 1'b0; tgt = '0; tcause = 2'd0;
            if (trap_i) begin
                redir = 1'b1; tgt = TV; tcause = 2'd1;
            end else if (jump_i || branch_taken_i) begin
                redir = 1'b1;
                tgt = jump_i ? jump_target_i : branch_target_i;
                if (tgt % 4 != 0) begin
                    tgt = TV; tcause = 2'd2;
                end
            end
            e_next = pc_i + 32'd4; e_we = 1'b0; e_fl = 1'b0; nxt = m_mode;
            check("m_state", state_o, m_mode);
            check("m_epc", trap_epc_o, m_epc);
            check("m_cause", trap_cause_o, m_cause);
            check("m_cnt", redirect_cnt_o, m_cnt);
            case (m_mode)
                M_BOOT: begin e_next = RV; e_we = 1'b1; nxt = M_RUN; end
                M_RUN: begin
                    if (redir) begin
                        e_fl = 1'b1; e_next = tgt; e_we = imem_ready_i;
                        if (!imem_ready_i) begin nxt = M_WAIT; m_pend = tgt; end
                        if (tcause != 0) begin m_epc = pc_i; m_cause = tcause; end
                        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                    end else if (halt_i) begin
                        nxt = M_HALT;
                    end else begin
                        e_we = imem_ready_i && !stall_i;
                    end
                end
                M_WAIT: begin
                    if (trap_i) begin
                        e_fl = 1'b1; m_pend = TV; m_epc = pc_i; m_cause = 2'd1;
                        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                    end
                    e_next = m_pend; e_we = imem_ready_i;
                    if (imem_ready_i) nxt = M_RUN;
                end
                default: ;
            endcase
            check("m_we", pc_write_en_o, e_we);
            check("m_flush_if_id", flush_if_id_o, e_fl);
            check("m_flush_id_ex", flush_id_ex_o, e_fl);
            if (e_we) check("m_pc_next", pc_next_o, e_next);
            m_mode = nxt;
        end
    end

    // PC register stand-in: follows the DUT's write requests.
    logic        cap_we;
    logic [31:0] cap_next;

    task automatic settle();
        @(negedge clk);
        #1;
        cap_we = pc_write_en_o;
        cap_next = pc_next_o;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        if (cap_we) pc_i = cap_next;
    endtask

    task automatic quiet();
        stall_i = 0; branch_taken_i = 0; jump_i = 0; trap_i = 0; halt_i = 0; imem_ready_i = 1;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        int halt_cycles;
        quiet();
        rst_n = 0;
        repeat (3) begin settle(); adv(); end
        rst_n = 1;
        // Boot then sequential fetch.
        settle();
        check("boot_state", state_o, 0);
        check("boot_pc", pc_next_o, RV);
        check("boot_we", pc_write_en_o, 1);
        adv();
        settle(); check("seq_pc0", pc_i, 32'h0); check("seq_next0", pc_next_o, 32'h4); check("run_state", state_o, 1);
        adv();
        settle(); check("seq_pc4", pc_i, 32'h4);
        adv();
        settle(); check("seq_pc8", pc_i, 32'h8);
        adv();

        // Stall, then a branch that overrides the stall.
        pc_i = 32'h20; stall_i = 1;
        settle(); check("stall_we1", pc_write_en_o, 0);
        adv();
        settle(); check("stall_we2", pc_write_en_o, 0);
        adv();
        branch_taken_i = 1; branch_target_i = 32'h80;
        settle();
        check("br_pc", pc_next_o, 32'h80); check("br_we", pc_write_en_o, 1);
        check("br_fl1", flush_if_id_o, 1); check("br_fl2", flush_id_ex_o, 1);
        adv(); quiet();

        // Jump under back-pressure parks the target.
        jump_i = 1; jump_target_i = 32'h40; imem_ready_i = 0;
        settle(); check("jw_flush", flush_if_id_o, 1); check("jw_we0", pc_write_en_o, 0);
        adv();
        settle(); check("jw_state", state_o, 2); check("jw_we1", pc_write_en_o, 0); check("jw_noflush", flush_id_ex_o, 0);
        adv();
        settle(); check("jw_we2", pc_write_en_o, 0);
        adv();
        quiet();
        settle(); check("jw_release_we", pc_write_en_o, 1); check("jw_release_pc", pc_next_o, 32'h40);
        adv();
        settle(); check("jw_back_run", state_o, 1); check("jw_pc", pc_i, 32'h40);
        adv();

        // Misaligned branch target becomes a trap.
        pc_i = 32'h44; branch_taken_i = 1; branch_target_i = 32'h42;
        settle(); check("mis_pc", pc_next_o, TV);
        adv(); quiet();
        settle(); check("mis_cause", trap_cause_o, 2); check("mis_epc", trap_epc_o, 32'h44);
        adv();

        // Trap while waiting replaces the parked target.
        jump_i = 1; jump_target_i = 32'h60; imem_ready_i = 0;
        settle(); adv();
        jump_i = 0; trap_i = 1;
        settle(); check("wt_flush", flush_if_id_o, 1); check("wt_we", pc_write_en_o, 0);
        adv(); quiet();
        settle(); check("wt_pc", pc_next_o, TV); check("wt_we1", pc_write_en_o, 1); check("wt_cause", trap_cause_o, 1);
        adv();

        // Halt together with trap: trap wins. Then halt alone.
        halt_i = 1; trap_i = 1;
        settle(); check("ht_pc", pc_next_o, TV); check("ht_flush", flush_if_id_o, 1);
        adv(); quiet();
        settle(); check("ht_state", state_o, 1);
        adv();
        halt_i = 1;
        settle(); check("h_we", pc_write_en_o, 0);
        adv(); quiet();
        for (int i = 0; i < 4; i++) begin
            trap_i = i[0]; jump_i = 1; jump_target_i = 32'h300;
            settle(); check("h_state", state_o, 3); check("h_we_hold", pc_write_en_o, 0); check("h_noflush", flush_if_id_o, 0);
            adv();
        end
        quiet();

        // Reset in the middle of a parked redirect.
        rst_n = 0; settle(); adv(); rst_n = 1;
        settle(); adv();
        jump_i = 1; jump_target_i = 32'h200; imem_ready_i = 0;
        settle(); adv(); quiet(); imem_ready_i = 0;
        settle(); check("rw_state", state_o, 2); check("rw_cnt", redirect_cnt_o, 1);
        adv();
        rst_n = 0;
        settle(); check("rw_rst_cnt", redirect_cnt_o, 0); check("rw_rst_state", state_o, 0);
        adv();
        rst_n = 1; imem_ready_i = 1;
        settle(); check("rw_boot", state_o, 0); check("rw_boot_pc", pc_next_o, RV);
        adv();
        settle(); check("rw_run", state_o, 1); check("rw_pc", pc_i, RV);
        adv();

        // Sequential wrap.
        pc_i = 32'hFFFF_FFFC;
        settle(); check("wrap_pc", pc_next_o, 32'h0);
        adv();

        // Randomized traffic.
        halt_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            rst_n = !(halt_cycles > 4 || $urandom_range(0, 499) == 0);
            trap_i          = ($urandom_range(0, 99) < 4);
            jump_i          = ($urandom_range(0, 9) == 0);
            branch_taken_i  = ($urandom_range(0, 99) < 15);
            halt_i          = ($urandom_range(0, 199) == 0);
            stall_i         = ($urandom_range(0, 4) == 0);
            imem_ready_i    = ($urandom_range(0, 3) != 0);
            jump_target_i   = rand_target();
            branch_target_i = rand_target();
            if ($urandom_range(0, 19) == 0) pc_i = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : ($urandom & ~32'h3);
            settle();
            halt_cycles = (state_o == 2'd3) ? halt_cycles + 1 : 0;
            adv();
        end
        quiet();
        rst_n = 1;

        // Saturation of the redirect counter.
        rst_n = 0; settle(); adv(); rst_n = 1;
        settle(); adv();
        for (int i = 0; i < 65540; i++) begin
            jump_i = 1; jump_target_i = $urandom & ~32'h3;
            settle(); adv();
        end
        quiet();
        settle(); check("sat_cnt", redirect_cnt_o, 32'hFFFF);
        adv();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h00000000, first fetch address loaded after reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h00000100, redirect target for traps and misaligned targets.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 pc_i  in  32  current PC from the PC register.
REQ-006 imem_ready_i  in  1  instruction memory can accept a fetch this cycle.
REQ-007 stall_i  in  1  pipeline hazard stall request.
REQ-008 branch_taken_i / branch_target_i  in  1 / 32  resolved taken branch and its target.
REQ-009 jump_i / jump_target_i  in  1 / 32  jump (JAL/JALR) and its target.
REQ-010 trap_i  in  1  exception/interrupt request.
REQ-011 halt_i  in  1  halt request (EBREAK).
REQ-012 pc_next_o / pc_write_en_o  out  32 / 1  next PC and write enable to the PC register; combinational.
REQ-013 flush_if_id_o / flush_id_ex_o  out  1 / 1  squash wrong-path stages; combinational.
REQ-014 state_o  out  2  FSM state: BOOT=0, RUN=1, WAIT=2, HALT=3.
REQ-015 trap_epc_o / trap_cause_o  out  32 / 2  registered; PC and cause of the last trap (1=trap_i, 2=misaligned target).
REQ-016 redirect_cnt_o  out  16  registered; saturating count of accepted redirects.

Function
REQ-017 The redirect source SHALL be chosen by priority: trap_i > jump_i > branch_taken_i; the target SHALL be TRAP_VECTOR, jump_target_i or branch_target_i respectively.
REQ-018 A jump or branch target with bits [1:0] != 0 SHALL be replaced by TRAP_VECTOR and recorded as cause 2; trap_epc_o SHALL capture pc_i.
REQ-019 BOOT SHALL last exactly one cycle: pc_next_o=RESET_VECTOR, pc_write_en_o=1, independent of imem_ready_i; next state RUN.
REQ-020 RUN with no redirect: pc_next_o=pc_i+4 (modulo 2^32, so 32'hFFFFFFFC wraps to 0); pc_write_en_o=imem_ready_i & ~stall_i.
REQ-021 RUN with a redirect and imem_ready_i=1: pc_next_o=target, pc_write_en_o=1, both flushes=1, stay RUN; stall_i is overridden.
REQ-022 RUN with a redirect and imem_ready_i=0: pc_write_en_o=0, both flushes=1 this cycle, target latched into the pending register, next state WAIT.
REQ-023 WAIT: pc_next_o=pending target, pc_write_en_o=imem_ready_i, flushes=0; return to RUN on the cycle imem_ready_i=1.
REQ-024 In WAIT, branch_taken_i, jump_i, stall_i and halt_i SHALL be ignored.
REQ-025 In WAIT, trap_i SHALL overwrite the pending target with TRAP_VECTOR, assert both flushes, and update trap_epc_o/trap_cause_o.
REQ-026 RUN with halt_i=1 and no redirect: pc_write_en_o=0, next state HALT; a simultaneous redirect SHALL win and halt_i is dropped.
REQ-027 HALT SHALL hold pc_write_en_o=0 and flushes=0 and ignore all inputs until reset.
REQ-028 Each accepted trap (cause 1 or 2) SHALL latch trap_epc_o=pc_i and the cause on the next edge.
REQ-029 redirect_cnt_o SHALL increment once per redirect accepted in RUN or WAIT and SHALL saturate at 16'hFFFF.

Reset
REQ-030 On rst_n=0, asynchronously: state=BOOT, pending target=0, trap_epc_o=0, trap_cause_o=0, redirect_cnt_o=0.
REQ-031 Reset asserted in any state, including mid-WAIT, SHALL discard any pending redirect; the first cycle after release is BOOT.

Verification
REQ-032 Release reset, imem_ready_i=1 -> cycle 1 pc_next_o=RESET_VECTOR with we=1; then pc_i=0,4,8 sequentially.
REQ-033 pc_i=32'h20, stall_i=1 for 2 cycles -> we=0 for both; branch_taken_i with target 32'h80 during the stall -> pc_next_o=32'h80, we=1, both flushes=1.
REQ-034 jump_i=1 with target 32'h40 and imem_ready_i=0 for 3 cycles -> flush for 1 cycle, state WAIT, we=0, then we=1 with pc_next_o=32'h40, state RUN.
REQ-035 Branch target 32'h42 -> pc_next_o=TRAP_VECTOR, trap_cause_o=2, trap_epc_o=pc_i; trap_i during WAIT -> pending target replaced by TRAP_VECTOR.
REQ-036 halt_i alone -> state HALT, we=0 held; halt_i with trap_i in the same cycle -> trap taken, state RUN.
REQ-037 Reset pulsed mid-WAIT -> redirect_cnt_o=0 and BOOT, with no stale target issued; 65536 redirects -> redirect_cnt_o stays at 16'hFFFF.
